// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   hz_state_t : sequencer state (RUN / IWAIT / DWAIT)
//   hz_cause_t : per-cycle winning hazard, listed highest priority first
//   WD_W       : width of the miss watchdog counter
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IWAIT = 2'd1,
    ST_DWAIT = 2'd2
  } hz_state_t;

  typedef enum logic [2:0] {
    C_NONE     = 3'd0,
    C_DMISS    = 3'd1,
    C_REDIRECT = 3'd2,
    C_LOAD_USE = 3'd3,
    C_IMISS    = 3'd4
  } hz_cause_t;

  localparam int WD_W = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: hazard inputs from the pipeline and caches,
// stage enables/flushes, watchdog flag and perf counters back to the pipeline.
//   master : pipeline side (drives hazard inputs, receives controls)
//   slave  : controller side
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              id_use_rs1, id_use_rs2;
  logic              ex_mem_read, ex_redirect;
  logic              icache_miss, icache_ready;
  logic              dcache_miss, dcache_ready;

  logic              pc_write, if_id_write, if_id_flush;
  logic              id_ex_write, id_ex_flush;
  logic              ex_mem_write, mem_wb_flush;
  logic              icache_abort, miss_timeout;
  logic [CNT_W-1:0]  perf_stall, perf_flush, perf_lu;

  modport master (
    output id_rs1, id_rs2, ex_rd, id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect,
           icache_miss, icache_ready, dcache_miss, dcache_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, icache_abort, miss_timeout,
           perf_stall, perf_flush, perf_lu
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect,
           icache_miss, icache_ready, dcache_miss, dcache_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, icache_abort, miss_timeout,
           perf_stall, perf_flush, perf_lu
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
//   clk, reset_n : clock, async active-low reset
//   inc, clr     : count enable, synchronous clear
//   count        : current value, holds at all-ones
module pipeline_hazard_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, EX redirects,
// I-cache and D-cache miss waits, sticky miss watchdog.
//   clk, reset_n : clock, async active-low reset (outputs forced to a safe
//                  freeze-and-flush pattern while reset is low)
//   bus (slave)  : hazard inputs in; stage enables/flushes, icache_abort,
//                  miss_timeout and perf_stall/perf_flush/perf_lu out
// Build option: HAZARD_PERF_EN enables the saturating perf counters;
// without it the perf ports read 0 and no counter flops exist.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int CNT_W        = 32,
  parameter int MISS_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pipeline_hazard_ctrl_if.slave bus
);
  hz_state_t         state, state_nxt;
  hz_cause_t         cause;
  logic              susp, susp_nxt;   // D-miss interrupted an I-miss wait
  logic              timeout_q;
  logic [WD_W-1:0]   wd;
  logic [REG_AW-1:0] ex_rd, id_rs1, id_rs2;
  logic              load_use, d_wait, i_wait, iwait_ctx;
  logic              pc_write, if_id_write, if_id_flush, id_ex_write;
  logic              id_ex_flush, ex_mem_write, mem_wb_flush, icache_abort;

  assign ex_rd  = bus.ex_rd;
  assign id_rs1 = bus.id_rs1;
  assign id_rs2 = bus.id_rs2;

  assign load_use = bus.ex_mem_read && (ex_rd != '0) &&
                    ((bus.id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (bus.id_use_rs2 && (id_rs2 == ex_rd)));

  // In DWAIT the ready cycle is evaluated as RUN, so the I-side looks at icache_miss.
  assign d_wait    = (state == ST_DWAIT) ? !bus.dcache_ready : bus.dcache_miss;
  assign i_wait    = (state == ST_IWAIT) ? !bus.icache_ready : bus.icache_miss;
  assign iwait_ctx = (state == ST_IWAIT) || ((state == ST_DWAIT) && susp);

  always_comb begin
    cause     = C_NONE;
    state_nxt = state;
    susp_nxt  = 1'b0;
    if (d_wait)               cause = C_DMISS;
    else if (bus.ex_redirect) cause = C_REDIRECT;
    else if (load_use)        cause = C_LOAD_USE;
    else if (i_wait)          cause = C_IMISS;

    if (cause == C_DMISS) begin
      state_nxt = ST_DWAIT;
      susp_nxt  = (state == ST_DWAIT) ? susp : (state == ST_IWAIT);
    end else if (cause == C_REDIRECT) begin
      state_nxt = ST_RUN;
    end else begin
      // a load-use overriding an I-miss still parks the fetch side in IWAIT
      state_nxt = (i_wait || ((state == ST_DWAIT) && susp)) ? ST_IWAIT : ST_RUN;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_flush = 1'b0;
    icache_abort = 1'b0;
    if (!reset_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else begin
      case (cause)
        C_DMISS: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_write = 1'b0;
          mem_wb_flush = 1'b1;
        end
        C_REDIRECT: begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          icache_abort = iwait_ctx || bus.icache_miss;
        end
        C_LOAD_USE: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
        C_IMISS: begin
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      susp      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      susp  <= susp_nxt;
      if (wd == WD_W'(MISS_TIMEOUT))
        timeout_q <= 1'b1;
    end
  end

  pipeline_hazard_ctrl_sat_counter #(.W(WD_W)) u_wd (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (state != ST_RUN),
    .clr     (state_nxt == ST_RUN),
    .count   (wd)
  );

`ifdef HAZARD_PERF_EN
  pipeline_hazard_ctrl_sat_counter #(.W(CNT_W)) u_perf_stall (
    .clk (clk), .reset_n (reset_n), .inc (!pc_write), .clr (1'b0), .count (bus.perf_stall)
  );
  pipeline_hazard_ctrl_sat_counter #(.W(CNT_W)) u_perf_flush (
    .clk (clk), .reset_n (reset_n), .inc (cause == C_REDIRECT), .clr (1'b0), .count (bus.perf_flush)
  );
  pipeline_hazard_ctrl_sat_counter #(.W(CNT_W)) u_perf_lu (
    .clk (clk), .reset_n (reset_n), .inc (cause == C_LOAD_USE), .clr (1'b0), .count (bus.perf_lu)
  );
`else
  assign bus.perf_stall = '0;
  assign bus.perf_flush = '0;
  assign bus.perf_lu    = '0;
`endif

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_write  = id_ex_write;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_write = ex_mem_write;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.icache_abort = icache_abort;
  assign bus.miss_timeout = timeout_q;
endmodule
